// File: rtl/alu_arbiter_if.sv
// Requester, response and shared-ALU signals of the two-port ALU arbiter.
// The arbiter takes the slave side; requesters and the ALU sit on the master side.
interface alu_arbiter_if #(
  parameter int W = 16
);
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [2:0]   req_op0;
  logic [2:0]   req_op1;
  logic [W-1:0] req_a0;
  logic [W-1:0] req_b0;
  logic [W-1:0] req_a1;
  logic [W-1:0] req_b1;

  logic [1:0]   resp_valid;
  logic [1:0]   resp_ready;
  logic [W-1:0] resp_result;
  logic [15:0]  resp_status;

  logic [W-1:0] alu_data1;
  logic [W-1:0] alu_data2;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_result;
  logic [15:0]  alu_status;

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
    input  resp_ready, alu_result, alu_status,
    output req_ready, resp_valid, resp_result, resp_status,
    output alu_data1, alu_data2, alu_op
  );

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
    output resp_ready, alu_result, alu_status,
    input  req_ready, resp_valid, resp_result, resp_status,
    input  alu_data1, alu_data2, alu_op
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// one operation in flight: IDLE (grant) -> EXEC (one ALU cycle) -> RESP (hold result).
module alu_arbiter #(
  parameter int W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state_reg;
  state_t       state_next;
  logic         prio_reg;
  logic         owner_reg;
  logic [2:0]   op_reg;
  logic [W-1:0] a_reg;
  logic [W-1:0] b_reg;
  logic [W-1:0] result_reg;
  logic [15:0]  status_reg;

  logic [2:0]   port_op [2];
  logic [W-1:0] port_a  [2];
  logic [W-1:0] port_b  [2];
  logic [1:0]   grant;
  logic [1:0]   resp_valid_vec;
  logic         grant_idx;
  logic         accept;
  logic         resp_done;

  assign port_op[0] = bus.req_op0;
  assign port_op[1] = bus.req_op1;
  assign port_a[0]  = bus.req_a0;
  assign port_a[1]  = bus.req_a1;
  assign port_b[0]  = bus.req_b0;
  assign port_b[1]  = bus.req_b1;

  // A port wins if it is the only requester or the pointer favours it.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign grant[gi] = bus.req_valid[gi] &
                         (~bus.req_valid[1-gi] | (prio_reg == 1'(gi)));
      assign resp_valid_vec[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
    end
  endgenerate

  assign grant_idx = grant[1];
  assign accept    = (state_reg == IDLE) && (grant != 2'b00);
  assign resp_done = (state_reg == RESP) && bus.resp_ready[owner_reg];

  always_comb begin
    state_next    = state_reg;
    bus.req_ready = 2'b00;
    case (state_reg)
      IDLE: begin
        bus.req_ready = grant;
        if (accept) begin
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (resp_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_reg   <= 1'b0;
      owner_reg  <= 1'b0;
      op_reg     <= 3'b000;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      status_reg <= 16'h0000;
    end else begin
      if (accept) begin
        prio_reg  <= ~grant_idx;
        owner_reg <= grant_idx;
        op_reg    <= port_op[grant_idx];
        a_reg     <= port_a[grant_idx];
        b_reg     <= port_b[grant_idx];
      end
      // The ALU sees the operand registers throughout EXEC; sample at its end.
      if (state_reg == EXEC) begin
        result_reg <= bus.alu_result;
        status_reg <= bus.alu_status;
      end
    end
  end

  assign bus.alu_op      = op_reg;
  assign bus.alu_data1   = a_reg;
  assign bus.alu_data2   = b_reg;
  assign bus.resp_result = result_reg;
  assign bus.resp_status = status_reg;
  assign bus.resp_valid  = resp_valid_vec;
  assign busy            = (state_reg != IDLE);

endmodule
